clint_timer: RTL and testbench
==============================

Name: clint_timer

Overview:
- Core-local interruptor for the RISC-V SoC; the slave that consumes clint_ren/clint_wen from the system bus decoder and returns clint_data_out.
- Holds the 64-bit mtime counter, the 64-bit mtimecmp compare register and the msip software-interrupt bit.
- Drives the machine timer and software interrupt lines into the core's CSR/trap logic.

Parameters:
- CLK_DIV, 27, clk cycles per mtime increment (27 MHz to 1 MHz); legal range 1..65535.
- RESET_MTIMECMP, 64'hFFFF_FFFF_FFFF_FFFF, reset value of mtimecmp (no interrupt out of reset).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- addr  input  16  byte offset within the CLINT window (data_addr[15:0]); bits [1:0] ignored.
- ren  input  1  read strobe from the bus decoder (clint_ren).
- wen  input  1  write strobe from the bus decoder (clint_wen).
- wdata  input  32  write data.
- byte_en  input  4  byte write enables for wdata[31:0]; bit n covers wdata[8n+7:8n].
- rdata  output  32  read data, routed to clint_data_out.
- timer_irq  output  1  machine timer interrupt (MTIP).
- soft_irq  output  1  machine software interrupt (MSIP).
- tick  output  1  one-cycle pulse on each mtime increment.

Behaviour:
- Reset is asynchronous on reset=1. Reset values:
  - mtime=0, mtimecmp=RESET_MTIMECMP, msip=0, prescaler=0.
  - rdata=0, timer_irq=0, soft_irq=0, tick=0.
- Register map (word offsets):
  - 0x0000 msip: bit0 R/W; bits [31:1] read 0 and ignore writes.
  - 0x4000 mtimecmp[31:0]; 0x4004 mtimecmp[63:32].
  - 0xBFF8 mtime[31:0]; 0xBFFC mtime[63:32].
  - Any other offset reads 0 and ignores writes.
- Prescaler:
  - Counts 0..CLK_DIV-1 and wraps to 0.
  - On the cycle it equals CLK_DIV-1, tick=1 (registered) on the next cycle and mtime increments by 1 on the same edge.
  - With CLK_DIV=1, mtime increments every cycle and tick is constantly 1.
- mtime is a 64-bit counter that wraps from FFFF_FFFF_FFFF_FFFF to 0 with no flag. The carry from the low to the high word happens on the same edge.
- Writes:
  - Take effect at the clk edge where wen=1; only the byte lanes with byte_en set are updated.
  - A write to either mtime half on a tick edge wins. The written half takes the write data; the other half keeps its pre-edge value with no increment and no carry. That tick is lost.
  - A write does not reset the prescaler.
- Reads:
  - rdata is registered, with 1-cycle latency: the value sampled at edge N with ren=1 appears after edge N.
  - rdata holds its last value while ren=0.
  - Read data reflects register contents before any same-edge write or increment.
  - ren and wen together: the write is performed and rdata returns the old value.
- timer_irq:
  - Registered. timer_irq = (mtime >= mtimecmp), an unsigned 64-bit compare evaluated on post-update values, visible 1 cycle after the causing edge.
  - It is level, not sticky. It clears 1 cycle after software writes mtimecmp above mtime.
- soft_irq = msip, a direct register output.
- No handshake or wait states. The block accepts one access per cycle, back-to-back.
- Reset asserted mid-operation clears all state immediately. The prescaler restarts from 0 after release.

Test Plan:
- Reset release, CLK_DIV=27 -> first tick 27 cycles after release; mtime=1 after that edge; timer_irq=0 and soft_irq=0 throughout.
- Write 0x0000_0001 to 0x0000, then write 0 -> soft_irq=1 from the cycle after the first write; soft_irq=0 after the second; a read of 0x0000 returns 1 then 0.
- CLK_DIV=1; write mtime lo/hi=0xFFFF_FFFE/0xFFFF_FFFF; mtimecmp=0xFFFF_FFFF_FFFF_FFFF:
  - timer_irq=1 once mtime=0xFFFF_FFFF_FFFF_FFFF.
  - Next edge mtime wraps to 0 and timer_irq returns to 0.
- CLK_DIV=1; mtime=0x0000_0000_FFFF_FFFF -> mtime reads 0x0000_0001_0000_0000 in the next cycle (carry on the same edge).
- Write 0x0000_0010 to mtimecmp lo and 0 to mtimecmp hi with mtime=0x0F, CLK_DIV=4:
  - timer_irq rises 1 cycle after mtime reaches 0x10.
  - A write of 0x0000_0100 to mtimecmp lo drops timer_irq the next cycle.
- Write mtime lo with byte_en=4'b0010, wdata=0x0000_AB00, coincident with a tick:
  - mtime[15:8]=0xAB, other bytes unchanged, no increment that edge.
  - A simultaneous ren to 0xBFF8 returns the pre-write value.

Source files
------------

// File: rtl/clint_timer.sv
// clint_timer: RISC-V CLINT holding mtime, mtimecmp and msip.
// Drives the timer and software interrupts; rdata is registered with a 1-cycle latency.
module clint_timer #(
    parameter int          CLK_DIV        = 27,
    parameter logic [63:0] RESET_MTIMECMP = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] addr,
    input  logic        ren,
    input  logic        wen,
    input  logic [31:0] wdata,
    input  logic [3:0]  byte_en,
    output logic [31:0] rdata,
    output logic        timer_irq,
    output logic        soft_irq,
    output logic        tick
);
    localparam logic [15:0] DIV_MAX = 16'(CLK_DIV - 1);

    logic [15:0] presc;
    logic [63:0] mtime, mtimecmp, mtime_n, cmp_n;
    logic [31:0] bmask, rd;
    logic        msip, step, unused;
    logic        sel_msip, sel_cmp_lo, sel_cmp_hi, sel_mt_lo, sel_mt_hi;

    assign unused     = ^addr[1:0];
    assign bmask      = {{8{byte_en[3]}}, {8{byte_en[2]}}, {8{byte_en[1]}}, {8{byte_en[0]}}};
    assign sel_msip   = addr[15:2] == 14'h0000;
    assign sel_cmp_lo = addr[15:2] == 14'h1000;
    assign sel_cmp_hi = addr[15:2] == 14'h1001;
    assign sel_mt_lo  = addr[15:2] == 14'h2FFE;
    assign sel_mt_hi  = addr[15:2] == 14'h2FFF;
    assign step       = presc == DIV_MAX;
    assign soft_irq   = msip;

    // A write to either mtime half overrides the increment, so that tick is dropped.
    always_comb begin
        mtime_n = step ? mtime + 64'd1 : mtime;
        if (wen && sel_mt_lo) mtime_n = {mtime[63:32], (mtime[31:0] & ~bmask) | (wdata & bmask)};
        if (wen && sel_mt_hi) mtime_n = {(mtime[63:32] & ~bmask) | (wdata & bmask), mtime[31:0]};
        cmp_n = mtimecmp;
        if (wen && sel_cmp_lo) cmp_n[31:0] = (mtimecmp[31:0] & ~bmask) | (wdata & bmask);
        if (wen && sel_cmp_hi) cmp_n[63:32] = (mtimecmp[63:32] & ~bmask) | (wdata & bmask);
    end

    always_comb begin
        rd = sel_msip   ? {31'd0, msip}    :
             sel_cmp_lo ? mtimecmp[31:0]   :
             sel_cmp_hi ? mtimecmp[63:32]  :
             sel_mt_lo  ? mtime[31:0]      :
             sel_mt_hi  ? mtime[63:32]     : 32'd0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc     <= '0;
            mtime     <= '0;
            mtimecmp  <= RESET_MTIMECMP;
            msip      <= 1'b0;
            rdata     <= '0;
            timer_irq <= 1'b0;
            tick      <= 1'b0;
        end else begin
            presc     <= step ? 16'd0 : presc + 16'd1;
            tick      <= step;
            mtime     <= mtime_n;
            mtimecmp  <= cmp_n;
            timer_irq <= mtime >= mtimecmp;
            if (wen && sel_msip && byte_en[0]) msip <= wdata[0];
            if (ren) rdata <= rd;
        end
    end
endmodule

// File: tb/tb_clint_timer.sv
// tb_clint_timer: directed checks of clint_timer at CLK_DIV = 27, 1 and 4.
module tb_clint_timer;
    logic        clk, reset, ren, wen;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  byte_en;
    logic [31:0] rd27, rd1, rd4;
    logic        ti27, ti1, ti4, si27, si1, si4, tk27, tk1, tk4;
    int          compared = 0, mismatched = 0;

    clint_timer #(.CLK_DIV(27)) u27 (.clk(clk), .reset(reset), .addr(addr), .ren(ren), .wen(wen),
        .wdata(wdata), .byte_en(byte_en), .rdata(rd27), .timer_irq(ti27), .soft_irq(si27), .tick(tk27));
    clint_timer #(.CLK_DIV(1)) u1 (.clk(clk), .reset(reset), .addr(addr), .ren(ren), .wen(wen),
        .wdata(wdata), .byte_en(byte_en), .rdata(rd1), .timer_irq(ti1), .soft_irq(si1), .tick(tk1));
    clint_timer #(.CLK_DIV(4)) u4 (.clk(clk), .reset(reset), .addr(addr), .ren(ren), .wen(wen),
        .wdata(wdata), .byte_en(byte_en), .rdata(rd4), .timer_irq(ti4), .soft_irq(si4), .tick(tk4));

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic        w, r;
        logic [15:0] a;
        logic [31:0] d;
        logic [3:0]  be;
        logic [31:0] exp_rd;
        logic        exp_si;
    } vec_t;
    vec_t tbl [17];

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic bus(input logic w, input logic r, input logic [15:0] a, input logic [31:0] d, input logic [3:0] be);
        wen = w; ren = r; addr = a; wdata = d; byte_en = be;
        cyc();
        wen = 0; ren = 0;
    endtask

    task automatic do_reset();
        wen = 0; ren = 0;
        reset = 1;
        cyc();
        cyc();
        reset = 0;
    endtask

    initial begin
        int first, bad;
        reset = 1; ren = 0; wen = 0; addr = 0; wdata = 0; byte_en = 0;
        cyc();
        chk("reset_rdata", rd27, 0);
        chk("reset_tick", tk27, 0);
        chk("reset_tick_div1", tk1, 0);
        chk("reset_timer", ti27, 0);
        chk("reset_soft", si27, 0);
        reset = 0;
        first = 0; bad = 0;
        for (int i = 1; i <= 40 && first == 0; i++) begin
            cyc();
            if (tk27) first = i;
            if (ti27 || si27) bad = 1;
        end
        chk("first_tick_cycle", first, 27);
        chk("irq_quiet", bad, 0);
        bus(0, 1, 16'hBFF8, 0, 0);
        chk("mtime_after_tick", rd27, 1);
        chk("tick_one_cycle", tk27, 0);

        tbl[0]  = '{1'b1, 1'b0, 16'h0000, 32'h0000_0001, 4'hF, 32'h0000_0001, 1'b1};
        tbl[1]  = '{1'b0, 1'b1, 16'h0000, 32'h0,         4'h0, 32'h0000_0001, 1'b1};
        tbl[2]  = '{1'b1, 1'b0, 16'h0000, 32'hFFFF_FFFE, 4'hF, 32'h0000_0001, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 16'h0000, 32'h0,         4'h0, 32'h0000_0000, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 16'h0000, 32'hFFFF_FFFF, 4'hE, 32'h0000_0000, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 16'h0000, 32'h0,         4'h0, 32'h0000_0000, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 16'h4000, 32'h1234_5678, 4'hF, 32'h0000_0000, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 16'h4000, 32'h0,         4'h0, 32'h1234_5678, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 16'h4004, 32'hAABB_CCDD, 4'h5, 32'h1234_5678, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 16'h4004, 32'h0,         4'h0, 32'hFFBB_FFDD, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 16'h1234, 32'hDEAD_BEEF, 4'hF, 32'hFFBB_FFDD, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 16'h1234, 32'h0,         4'h0, 32'h0000_0000, 1'b0};
        tbl[12] = '{1'b1, 1'b1, 16'h4000, 32'h0,         4'hF, 32'h1234_5678, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 16'h4000, 32'h0,         4'h0, 32'h1234_5678, 1'b0};
        tbl[14] = '{1'b0, 1'b1, 16'h4000, 32'h0,         4'h0, 32'h0000_0000, 1'b0};
        tbl[15] = '{1'b1, 1'b1, 16'h0000, 32'hFFFF_FFFF, 4'hF, 32'h0000_0000, 1'b1};
        tbl[16] = '{1'b0, 1'b1, 16'h0000, 32'h0,         4'h0, 32'h0000_0001, 1'b1};
        for (int i = 0; i < 17; i++) begin
            bus(tbl[i].w, tbl[i].r, tbl[i].a, tbl[i].d, tbl[i].be);
            chk($sformatf("vec%0d_rdata", i), rd27, tbl[i].exp_rd);
            chk($sformatf("vec%0d_soft", i), si27, tbl[i].exp_si);
        end
        chk("tbl_timer_low", ti27, 0);

        reset = 1;
        #1;
        chk("async_reset_soft", si27, 0);
        chk("async_reset_rdata", rd27, 0);

        do_reset();
        bus(1, 0, 16'hBFF8, 32'hFFFF_FFFE, 4'hF);
        bus(1, 0, 16'hBFFC, 32'hFFFF_FFFF, 4'hF);
        bus(0, 1, 16'hBFF8, 0, 0);
        chk("wrap_lo_pre", rd1, 32'hFFFF_FFFE);
        chk("wrap_irq_pre", ti1, 0);
        chk("div1_tick_const", tk1, 1);
        bus(0, 1, 16'hBFFC, 0, 0);
        chk("wrap_hi_max", rd1, 32'hFFFF_FFFF);
        chk("wrap_irq_set", ti1, 1);
        bus(0, 1, 16'hBFF8, 0, 0);
        chk("wrap_lo_zero", rd1, 0);
        chk("wrap_irq_clear", ti1, 0);
        bus(0, 1, 16'hBFFC, 0, 0);
        chk("wrap_hi_zero", rd1, 0);

        do_reset();
        bus(1, 0, 16'hBFF8, 32'hFFFF_FFFF, 4'hF);
        bus(0, 1, 16'hBFF8, 0, 0);
        chk("carry_lo_pre", rd1, 32'hFFFF_FFFF);
        bus(0, 1, 16'hBFFC, 0, 0);
        chk("carry_hi", rd1, 1);
        bus(0, 1, 16'hBFF8, 0, 0);
        chk("carry_lo_next", rd1, 1);

        do_reset();
        bus(1, 0, 16'h4004, 0, 4'hF);
        bus(1, 0, 16'h4000, 32'h10, 4'hF);
        bus(1, 0, 16'hBFF8, 32'h0F, 4'hF);
        chk("cmp_no_tick_yet", tk4, 0);
        cyc();
        chk("cmp_tick_edge4", tk4, 1);
        chk("cmp_irq_lag", ti4, 0);
        bus(0, 1, 16'hBFF8, 0, 0);
        chk("cmp_mtime_0x10", rd4, 32'h10);
        chk("cmp_irq_rise", ti4, 1);
        bus(1, 0, 16'h4000, 32'h100, 4'hF);
        chk("cmp_irq_hold", ti4, 1);
        cyc();
        chk("cmp_irq_drop", ti4, 0);

        do_reset();
        repeat (7) cyc();
        bus(1, 1, 16'hBFF8, 32'h0000_AB00, 4'b0010);
        chk("lane_read_old", rd4, 1);
        bus(0, 1, 16'hBFF8, 0, 0);
        chk("lane_write_no_inc", rd4, 32'h0000_AB01);
        bus(0, 1, 16'hBFFC, 0, 0);
        chk("lane_hi_kept", rd4, 0);
        cyc();
        cyc();
        bus(0, 1, 16'hBFF8, 0, 0);
        chk("lane_presc_kept", rd4, 32'h0000_AB02);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
